topk_stream_sorter: RTL

- Clocked, parametrised successor to the combinational MinHash sorter.
- Consumes a stream of (signature, index) pairs and keeps the K pairs with the smallest signatures, or the largest when mode selects it.
- Implemented as a systolic insertion array; at frame end it emits the K indices in sorted order through a valid/ready handshake.
- Sits between the MinHash signature generator and the candidate-selection stage.

---
 rtl/minhash_pkg.sv | 27 ++
 rtl/topk_stream_sorter_if.sv | 32 +++
 rtl/sorter_cell.sv | 53 +++++
 rtl/topk_stream_sorter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/minhash_pkg.sv
// Shared types for the MinHash top-K sorter: key/payload widths, slot entry, FSM states.
package minhash_pkg;

    localparam int unsigned SIGNATURE_WIDTH = 32;
    localparam int unsigned INDEX_WIDTH     = 10;

    typedef logic [SIGNATURE_WIDTH-1:0] sig_t;
    typedef logic [INDEX_WIDTH-1:0]     idx_t;

    typedef struct packed {
        logic valid;
        sig_t sig;
        idx_t idx;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } sorter_state_t;

    // True when a held entry ranks strictly behind key s (ties favour the held entry)
    function automatic logic is_worse(input entry_t e, input sig_t s, input logic max_mode);
        return e.valid && (max_mode ? (e.sig < s) : (e.sig > s));
    endfunction

endpackage

// File: rtl/topk_stream_sorter_if.sv
// Beat stream in, sorted top-K result out, each with its own valid/ready handshake.
interface topk_stream_sorter_if #(
    parameter int unsigned NUM_COMPARATORS = 8,
    parameter int unsigned LOG_COMPARATORS = 3
);
    import minhash_pkg::*;

    logic                                   mode;
    logic                                   valid_in;
    logic                                   ready_in;
    logic                                   last_in;
    sig_t                                   signature_in;
    idx_t                                   index_in;
    logic                                   valid_out;
    logic                                   ready_out;
    logic [NUM_COMPARATORS*INDEX_WIDTH-1:0] indices_out;
    logic [NUM_COMPARATORS-1:0]             entry_valid_out;
    logic [LOG_COMPARATORS:0]               count_out;

    // Upstream producer and downstream consumer side
    modport master (
        output mode, valid_in, last_in, signature_in, index_in, ready_out,
        input  ready_in, valid_out, indices_out, entry_valid_out, count_out
    );

    // Sorter side
    modport slave (
        input  mode, valid_in, last_in, signature_in, index_in, ready_out,
        output ready_in, valid_out, indices_out, entry_valid_out, count_out
    );

endinterface

// File: rtl/sorter_cell.sv
// One slot of the systolic insertion array: keeps, replaces, or shifts in its entry.
module sorter_cell
    import minhash_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   insert_i,   // accepted beat this cycle
    input  logic   clear_i,    // first beat of a frame: treat the array as empty
    input  logic   mode_i,     // 0 keep smallest, 1 keep largest
    input  sig_t   sig_i,
    input  idx_t   idx_i,
    input  logic   flag_i,     // new pair lands in a lower slot
    input  entry_t entry_i,    // registered entry of the slot below
    output logic   flag_c_o,   // new pair lands in this slot or a lower one
    output entry_t entry_o
);

    entry_t entry_q;
    entry_t entry_d;
    entry_t own_eff;
    entry_t below_eff;
    logic   take;

    // Slot decision: shift from below, capture the new pair, or hold
    always_comb begin
        own_eff   = clear_i ? entry_t'('0) : entry_q;
        below_eff = clear_i ? entry_t'('0) : entry_i;
        take      = !own_eff.valid || is_worse(own_eff, sig_i, mode_i);
        flag_c_o  = flag_i | take;
        entry_d   = entry_q;
        if (insert_i) begin
            if (flag_i) begin
                entry_d = below_eff;
            end else if (take) begin
                entry_d = '{valid: 1'b1, sig: sig_i, idx: idx_i};
            end else begin
                entry_d = own_eff;
            end
        end
    end

    // Slot register
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/topk_stream_sorter.sv
// Streaming top-K sorter: K insertion cells plus frame FSM, beat count and result handshake.
module topk_stream_sorter
    import minhash_pkg::*;
#(
    parameter int unsigned NUM_COMPARATORS = 8,
    parameter int unsigned LOG_COMPARATORS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    topk_stream_sorter_if.slave  bus
);

    localparam int unsigned K  = NUM_COMPARATORS;
    localparam int unsigned CW = LOG_COMPARATORS + 1;

    sorter_state_t   state_q;
    logic            ready_q;
    logic            valid_q;
    logic            mode_q;
    logic [CW-1:0]   count_q;

    logic            accept;
    logic            first;
    logic            mode_eff;

    entry_t          slot_q [K];
    logic [K:0]      flag_c;

    logic [K*INDEX_WIDTH-1:0] idx_vec;
    logic [K-1:0]             ev_vec;

    logic [SIGNATURE_WIDTH-1:0] unused_top_sig;
    logic                       unused_top_flag;

    assign accept   = bus.valid_in & ready_q;
    assign first    = accept & (state_q == IDLE);
    assign mode_eff = first ? bus.mode : mode_q;

    // Frame FSM with registered handshake outputs and saturating beat count
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        mode_q  <= bus.mode;
                        count_q <= CW'(1);
                        if (bus.last_in) begin
                            state_q <= HOLD;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (count_q != CW'(K)) begin
                            count_q <= count_q + CW'(1);
                        end
                        if (bus.last_in) begin
                            state_q <= HOLD;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.ready_out) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign flag_c[0] = 1'b0;

    // Insertion array; slot 0 holds the best entry
    for (genvar i = 0; i < K; i++) begin : g_cell
        entry_t below;
        if (i == 0) begin : g_bottom
            assign below = '0;
        end else begin : g_chain
            assign below = slot_q[i-1];
        end

        sorter_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .insert_i (accept),
            .clear_i  (first),
            .mode_i   (mode_eff),
            .sig_i    (bus.signature_in),
            .idx_i    (bus.index_in),
            .flag_i   (flag_c[i]),
            .entry_i  (below),
            .flag_c_o (flag_c[i+1]),
            .entry_o  (slot_q[i])
        );
    end

    // Flatten slot registers onto the result bus
    always_comb begin
        idx_vec = '0;
        ev_vec  = '0;
        for (int unsigned i = 0; i < K; i++) begin
            idx_vec[i*INDEX_WIDTH +: INDEX_WIDTH] = slot_q[i].idx;
            ev_vec[i]                             = slot_q[i].valid;
        end
    end

    // The top slot's key and the final insert flag have no consumer
    assign unused_top_sig  = slot_q[K-1].sig;
    assign unused_top_flag = flag_c[K];

    assign bus.ready_in        = ready_q;
    assign bus.valid_out       = valid_q;
    assign bus.count_out       = count_q;
    assign bus.indices_out     = idx_vec;
    assign bus.entry_valid_out = ev_vec;

endmodule
